// File: rtl/vote_logger.sv
// Vote logger: edge-detects candidate buttons in voting mode, keeps saturating tallies,
// and enforces a lockout window after every accepted vote. Optional VOTE_SYNC_EN adds 2-flop input synchronisers.
module vote_logger #(
   parameter int CNT_W          = 8,
   parameter int LOCKOUT_CYCLES = 100000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             mode,
   input  logic             candidate1_button_press,
   input  logic             candidate2_button_press,
   input  logic             candidate3_button_press,
   input  logic             candidate4_button_press,
   output logic             valid_vote_casted,
   output logic             invalid_vote,
   output logic [CNT_W-1:0] candidate1_vote,
   output logic [CNT_W-1:0] candidate2_vote,
   output logic [CNT_W-1:0] candidate3_vote,
   output logic [CNT_W-1:0] candidate4_vote,
   output logic             busy
);

   localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [LW-1:0]    LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
   localparam logic [LW-1:0]    LOCK_ONE  = LW'(1);
   localparam logic [CNT_W-1:0] TALLY_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TALLY_MAX = '1;

   typedef enum logic [1:0] {IDLE, LOCKOUT, WAIT_RELEASE} state_t;

   logic [3:0] btn_raw;
   logic [3:0] btn;
   logic [3:0] btn_q;
   logic [3:0] rise_d;

   state_t           state_q;
   logic [LW-1:0]    lock_cnt_q;
   logic [CNT_W-1:0] tally_q [4];
   logic             valid_q;
   logic             invalid_q;
   logic             busy_q;

   assign btn_raw = {candidate4_button_press, candidate3_button_press,
                     candidate2_button_press, candidate1_button_press};

`ifdef VOTE_SYNC_EN
   logic [3:0] sync1_q;
   logic [3:0] sync2_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   assign btn = sync2_q;
`else
   assign btn = btn_raw;
`endif

   // NOTE: every signal written in always_comb gets a value on every path, or a latch is inferred.
   always_comb begin
      rise_d = '0;
      rise_d = btn & ~btn_q;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         lock_cnt_q <= '0;
         btn_q      <= '0;
         valid_q    <= 1'b0;
         invalid_q  <= 1'b0;
         busy_q     <= 1'b0;
         // NOTE: the tally array is a handful of flops, not RAM, so it is cleared by reset like any register.
         for (int i = 0; i < 4; i++) tally_q[i] <= '0;
      end else begin
         btn_q     <= btn;
         valid_q   <= 1'b0;
         invalid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!mode && (rise_d != 4'b0000)) begin
                  if ($onehot(rise_d)) begin
                     for (int i = 0; i < 4; i++) begin
                        if (rise_d[i] && (tally_q[i] != TALLY_MAX))
                           tally_q[i] <= tally_q[i] + TALLY_ONE;
                     end
                     valid_q    <= 1'b1;
                     lock_cnt_q <= '0;
                     state_q    <= LOCKOUT;
                  end else begin
                     invalid_q <= 1'b1;
                     state_q   <= WAIT_RELEASE;
                  end
                  busy_q <= 1'b1;
               end
            end
            LOCKOUT: begin
               if (lock_cnt_q == LOCK_LAST) begin
                  if (|btn) begin
                     state_q <= WAIT_RELEASE;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  lock_cnt_q <= lock_cnt_q + LOCK_ONE;
               end
            end
            WAIT_RELEASE: begin
               if (btn == 4'b0000) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign valid_vote_casted = valid_q;
   assign invalid_vote      = invalid_q;
   assign busy              = busy_q;
   assign candidate1_vote   = tally_q[0];
   assign candidate2_vote   = tally_q[1];
   assign candidate3_vote   = tally_q[2];
   assign candidate4_vote   = tally_q[3];

endmodule

// File: tb/tb_vote_logger.sv
// Self-checking bench for vote_logger: scoreboard of expected vote events, checked
// against each strobe, plus direct checks of busy/lockout timing, saturation and reset.
module tb_vote_logger;

`ifdef VOTE_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clock;
   logic       reset;
   logic       mode;
   logic [3:0] btn;
   logic       valid;
   logic       invalid;
   logic [7:0] c1, c2, c3, c4;
   logic       busy;

   typedef struct {
      logic       is_valid;
      logic [7:0] t [4];
   } ev_t;

   ev_t        sb [$];
   ev_t        mon_ev;
   logic [7:0] exp_t [4];
   int         total = 0;
   int         bad   = 0;

   vote_logger #(.CNT_W(8), .LOCKOUT_CYCLES(10)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .mode                    (mode),
      .candidate1_button_press (btn[0]),
      .candidate2_button_press (btn[1]),
      .candidate3_button_press (btn[2]),
      .candidate4_button_press (btn[3]),
      .valid_vote_casted       (valid),
      .invalid_vote            (invalid),
      .candidate1_vote         (c1),
      .candidate2_vote         (c2),
      .candidate3_vote         (c3),
      .candidate4_vote         (c4),
      .busy                    (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push_event(input logic is_valid);
      ev_t e;
      e.is_valid = is_valid;
      for (int i = 0; i < 4; i++) e.t[i] = exp_t[i];
      sb.push_back(e);
   endtask

   task automatic expect_vote(input int c);
      if (exp_t[c] != 8'd255) exp_t[c] = exp_t[c] + 8'd1;
      push_event(1'b1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         tick(1);
         n++;
      end
      check("idle_timeout", busy, 0);
   endtask

   task automatic vote(input int c);
      expect_vote(c);
      btn[c] = 1'b1;
      tick(LAT);
      btn[c] = 1'b0;
      wait_idle();
   endtask

   task automatic check_tallies(input string tag);
      check({tag, "_c1"}, c1, exp_t[0]);
      check({tag, "_c2"}, c2, exp_t[1]);
      check({tag, "_c3"}, c3, exp_t[2]);
      check({tag, "_c4"}, c4, exp_t[3]);
   endtask

   // Every strobe must match the oldest expected event, tallies included.
   always @(negedge clock) begin
      if (reset && (valid || invalid)) begin
         check("pulse_exclusive", valid & invalid, 0);
         check("pulse_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            mon_ev = sb.pop_front();
            check("pulse_kind", valid, mon_ev.is_valid);
            check("ev_c1", c1, mon_ev.t[0]);
            check("ev_c2", c2, mon_ev.t[1]);
            check("ev_c3", c3, mon_ev.t[2]);
            check("ev_c4", c4, mon_ev.t[3]);
         end
      end
   end

   initial begin
      reset = 1'b0;
      mode  = 1'b0;
      btn   = 4'b0000;
      for (int i = 0; i < 4; i++) exp_t[i] = 8'd0;
      tick(2);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_invalid", invalid, 0);
      check_tallies("rst");
      reset = 1'b1;
      tick(1);

      // Single vote, strobe latency and 10-cycle lockout window
      expect_vote(1);
      btn = 4'b0010;
      tick(LAT - 1);
      check("t1_pre_strobe", valid, 0);
      tick(1);
      check("t1_strobe", valid, 1);
      check("t1_busy_on", busy, 1);
      check_tallies("t1");
      tick(2);
      btn = 4'b0000;
      tick(7);
      check("t1_busy_hi", busy, 1);
      tick(1);
      check("t1_busy_lo", busy, 0);
      check("t1_valid_one_shot", valid, 0);

      // Re-press inside lockout is ignored; press after lockout counts
      expect_vote(0);
      btn = 4'b0001;
      tick(LAT);
      check("t2_strobe", valid, 1);
      btn = 4'b0000;
      tick(3);
      btn = 4'b0001;
      tick(2);
      btn = 4'b0000;
      tick(LAT);
      check("t2_ignored", c1, 1);
      wait_idle();
      vote(0);
      check("t2_second", c1, 2);

      // Simultaneous rise: invalid pulse, then held through release
      push_event(1'b0);
      btn = 4'b0101;
      tick(LAT);
      check("t3_invalid", invalid, 1);
      check("t3_busy", busy, 1);
      tick(12);
      check("t3_held_busy", busy, 1);
      btn = 4'b0100;
      tick(LAT + 1);
      check("t3_one_held", busy, 1);
      btn = 4'b0000;
      tick(LAT);
      check("t3_released", busy, 0);
      check_tallies("t3");

      // Rise on cand3 while cand1 already held counts as a single vote
      mode = 1'b1;
      btn  = 4'b0001;
      tick(LAT + 2);
      check("th_mode1_busy", busy, 0);
      mode = 1'b0;
      expect_vote(2);
      btn = 4'b0101;
      tick(LAT);
      check("th_strobe", valid, 1);
      btn = 4'b0000;
      wait_idle();
      check_tallies("th");

      // Result-display mode ignores presses
      mode = 1'b1;
      btn  = 4'b1000;
      tick(LAT + 2);
      check("t4_no_count", c4, 0);
      check("t4_no_busy", busy, 0);
      btn = 4'b0000;
      tick(LAT + 1);
      mode = 1'b0;
      vote(3);
      check("t4_counted", c4, 1);

      // Saturation at 255
      while (exp_t[2] != 8'd255) vote(2);
      check("t5_at_max", c3, 255);
      vote(2);
      check("t5_saturated", c3, 255);

      // Reset mid-lockout with tallies 3/1/0/2
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) exp_t[i] = 8'd0;
      tick(1);
      vote(0); vote(0); vote(0); vote(1); vote(3);
      expect_vote(3);
      btn = 4'b1000;
      tick(LAT);
      btn = 4'b0000;
      tick(3);
      check("t6_in_lockout", busy, 1);
      check_tallies("t6_pre");
      reset = 1'b0;
      for (int i = 0; i < 4; i++) exp_t[i] = 8'd0;
      tick(1);
      check("t6_rst_busy", busy, 0);
      check_tallies("t6_post");
      reset = 1'b1;
      tick(1);
      vote(1);
      check("t6_after_rst", c2, 1);

      tick(3);
      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
